// File: rtl/lbm_readout_pkg.sv
// lbm_readout_pkg: shared states and default sizing for the GPIO frame reader
package lbm_readout_pkg;
  typedef enum logic [2:0] {IDLE, QUIET, DRIVE, SETTLE, CAPTURE, EMIT, DONE} state_t;
  localparam int HOST_TX_BIT       = 15;
  localparam int NUM_PIXELS_DEF    = 2500;
  localparam int IDX_W_DEF         = 15;
  localparam int DATA_W_DEF        = 16;
  localparam int SETTLE_CYCLES_DEF = 2;
endpackage

// File: rtl/readout_out_reg.sv
// readout_out_reg: one-entry valid/ready holding register for a captured sample
module readout_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         m_ready,
  output logic         m_valid,
  output logic [W-1:0] q
);
  // valid is set by a load and held until the consumer accepts; data only changes on load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      q       <= '0;
    end else begin
      m_valid <= load | (m_valid & ~m_ready);
      if (load) q <= d;
    end
  end
endmodule

// File: rtl/gpio_frame_reader.sv
// gpio_frame_reader: scans solver pixels over GPIO and streams samples; GPIO_READER_CHECKSUM_EN adds an rho checksum
module gpio_frame_reader
  import lbm_readout_pkg::*;
#(
  parameter int NUM_PIXELS    = NUM_PIXELS_DEF,
  parameter int IDX_W         = IDX_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_collision,
  output logic [15:0]       gpio_o,
  input  logic [DATA_W-1:0] gpio_ux,
  input  logic [DATA_W-1:0] gpio_uy,
  input  logic [DATA_W-1:0] gpio_rho,
  input  logic [DATA_W-1:0] gpio_u2,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [IDX_W-1:0]  m_pix,
  output logic [DATA_W-1:0] m_ux,
  output logic [DATA_W-1:0] m_uy,
  output logic [DATA_W-1:0] m_rho,
  output logic [DATA_W-1:0] m_u2,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       checksum
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int OW = 1 + IDX_W + 4 * DATA_W;
  state_t           state, state_n;
  logic [IDX_W-1:0] idx;
  logic [CW-1:0]    scnt;
  logic             hs, last_pix;
  assign hs       = m_valid & m_ready;
  assign last_pix = idx == IDX_W'(NUM_PIXELS - 1);
  assign busy     = state inside {QUIET, DRIVE, SETTLE, CAPTURE, EMIT};
  assign done     = state == DONE;
  // next-state: collision only gates the start of a pixel, never one already in flight
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? QUIET : IDLE;
      QUIET:   state_n = in_collision ? QUIET : DRIVE;
      DRIVE:   state_n = SETTLE;
      SETTLE:  state_n = scnt == CW'(SETTLE_CYCLES - 1) ? CAPTURE : SETTLE;
      CAPTURE: state_n = EMIT;
      EMIT:    state_n = hs ? (last_pix ? DONE : QUIET) : EMIT;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state, pixel index, settle timer, GPIO drive and frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      scnt      <= '0;
      gpio_o    <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      scnt      <= state == SETTLE ? scnt + 1'b1 : '0;
      idx       <= (state == EMIT && hs) ? (last_pix ? '0 : idx + 1'b1) : idx;
      gpio_o    <= state == DRIVE ? ((16'd1 << HOST_TX_BIT) | 16'(idx)) : (state_n == DONE ? '0 : gpio_o);
      frame_cnt <= state_n == DONE ? frame_cnt + 16'd1 : frame_cnt;
    end
  end
  readout_out_reg #(.W(OW)) u_out (
    .clk    (clk),
    .rst    (rst),
    .load   (state == CAPTURE),
    .d      ({last_pix, idx, gpio_ux, gpio_uy, gpio_rho, gpio_u2}),
    .m_ready(m_ready),
    .m_valid(m_valid),
    .q      ({m_last, m_pix, m_ux, m_uy, m_rho, m_u2})
  );
`ifdef GPIO_READER_CHECKSUM_EN
  logic [15:0] sum;
  assign checksum = sum;
  // wrapping rho sum over accepted samples, cleared when a frame is started
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum <= '0;
    else if (state == IDLE && start) sum <= '0;
    else if (hs) sum <= sum + 16'(m_rho);
  end
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_gpio_frame_reader.sv
// tb_gpio_frame_reader: directed table and sequence checks for gpio_frame_reader
module tb_gpio_frame_reader;
  logic        clk = 0, rst = 1, start = 0, in_collision = 0, m_ready = 1;
  logic [15:0] gpio_o, gpio_ux, gpio_uy, gpio_rho, gpio_u2;
  logic [15:0] m_ux, m_uy, m_rho, m_u2, frame_cnt, checksum;
  logic [14:0] m_pix;
  logic        m_valid, m_last, busy, done;
  logic [14:0] s_idx = '0;
  logic        rho_one = 0;
  int          pass_cnt = 0, tot_cnt = 0;
  int          exp_pix = 0, n_acc = 0, last_cnt = 0, done_cnt = 0, bad = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] f_ux(input int p); return 16'(p) ^ 16'h5A5A; endfunction
  function automatic logic [15:0] f_uy(input int p); return ~16'(p); endfunction
  function automatic logic [15:0] f_u2(input int p); return 16'(p * 3); endfunction
  function automatic logic [15:0] f_rho(input int p); return rho_one ? 16'd1 : 16'(p); endfunction

  // solver model: data follows the driven index one cycle late
  always @(posedge clk) s_idx <= gpio_o[14:0];
  assign gpio_ux  = f_ux(int'(s_idx));
  assign gpio_uy  = f_uy(int'(s_idx));
  assign gpio_rho = f_rho(int'(s_idx));
  assign gpio_u2  = f_u2(int'(s_idx));

  gpio_frame_reader dut (
    .clk(clk), .rst(rst), .start(start), .in_collision(in_collision), .gpio_o(gpio_o),
    .gpio_ux(gpio_ux), .gpio_uy(gpio_uy), .gpio_rho(gpio_rho), .gpio_u2(gpio_u2),
    .m_valid(m_valid), .m_ready(m_ready), .m_pix(m_pix), .m_ux(m_ux), .m_uy(m_uy),
    .m_rho(m_rho), .m_u2(m_u2), .m_last(m_last), .busy(busy), .done(done),
    .frame_cnt(frame_cnt), .checksum(checksum)
  );

  // stream monitor: order, data and last flag of every accepted sample
  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_pix = 0; n_acc = 0; last_cnt = 0; done_cnt = 0;
    end else begin
      if (done) done_cnt++;
      if (m_valid && m_ready) begin
        if (m_pix !== 15'(exp_pix) || m_rho !== f_rho(exp_pix) || m_ux !== f_ux(exp_pix) ||
            m_uy !== f_uy(exp_pix) || m_u2 !== f_u2(exp_pix) || m_last !== (exp_pix == 2499)) begin
          bad++;
          $display("FAIL mon_sample: got pix=%0d rho=%h ux=%h uy=%h u2=%h last=%b, expected pix=%0d rho=%h last=%b",
                   m_pix, m_rho, m_ux, m_uy, m_u2, m_last, exp_pix, f_rho(exp_pix), exp_pix == 2499);
        end
        if (m_last) last_cnt++;
        n_acc++;
        exp_pix = exp_pix == 2499 ? 0 : exp_pix + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic wait_gpio(input logic [15:0] val, input int limit, input string name);
    int n = 0;
    while (gpio_o !== val && n < limit) begin @(negedge clk); n++; end
    check(name, gpio_o, val);
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin @(negedge clk); n++; end
    check(name, done, 1);
  endtask

  typedef struct {
    logic        start, coll, rdy, v, b;
    logic [15:0] g;
    int          p;
  } vec_t;
  vec_t tbl[12];

  initial begin
    logic [15:0] exp_sum1, exp_sum2;
    logic        chg;
    int          n;
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8000, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8000, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8000, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8001, 0};
    exp_sum1 = '0;
    for (int p = 0; p < 2500; p++) exp_sum1 = exp_sum1 + 16'(p);
`ifdef GPIO_READER_CHECKSUM_EN
    exp_sum2 = 16'h09C4;
`else
    exp_sum1 = '0;
    exp_sum2 = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_gpio", gpio_o, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_checksum", checksum, 0);
    check("rst_done", done, 0);
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = tbl[i].start; in_collision = tbl[i].coll; m_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_valid", i), m_valid, tbl[i].v);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
      check($sformatf("tbl%0d_gpio", i), gpio_o, tbl[i].g);
      if (tbl[i].v) check($sformatf("tbl%0d_pix", i), m_pix, tbl[i].p);
    end
    @(negedge clk);
    start = 0; in_collision = 0; m_ready = 1;
    wait_gpio(16'h8007, 100, "gpio_pix7");
    in_collision = 1;
    chg = 0;
    repeat (20) begin @(negedge clk); if (gpio_o !== 16'h8007) chg = 1; end
    check("coll_gpio_held", chg, 0);
    check("coll_pix7_emitted", n_acc, 8);
    in_collision = 0;
    wait_gpio(16'h8008, 10, "gpio_pix8_after_coll");
    wait_gpio(16'h800A, 100, "gpio_pix10");
    m_ready = 0;
    n = 0;
    while (!m_valid && n < 20) begin @(negedge clk); n++; end
    check("stall_valid_rise", m_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", m_valid, 1);
      check("stall_pix", m_pix, 10);
      check("stall_rho", m_rho, 10);
    end
    m_ready = 1;
    wait_done(20000, "frame1_done");
    check("f1_frame_cnt", frame_cnt, 1);
    check("f1_busy_at_done", busy, 0);
    check("f1_gpio_at_done", gpio_o, 0);
    check("f1_checksum", checksum, exp_sum1);
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    check("start_at_done_ignored", busy, 0);
    check("f1_accepted", n_acc, 2500);
    check("f1_last_count", last_cnt, 1);
    check("f1_done_count", done_cnt, 1);
    check("f1_sample_errors", bad, 0);
    rho_one = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_gpio(16'h83E8, 10000, "gpio_pix1000");
    rst = 1;
    #1;
    check("midrst_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_gpio", gpio_o, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_checksum", checksum, 0);
    @(negedge clk);
    rst = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!m_valid && n < 20) begin @(negedge clk); n++; end
    check("f3_first_valid", m_valid, 1);
    check("f3_first_pix", m_pix, 0);
    wait_gpio(16'h8064, 2000, "gpio_pix100");
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done(20000, "frame3_done");
    check("f3_frame_cnt", frame_cnt, 1);
    check("f3_checksum", checksum, exp_sum2);
    @(negedge clk);
    check("f3_accepted", n_acc, 2500);
    check("f3_last_count", last_cnt, 1);
    check("f3_sample_errors", bad, 0);
    check("f3_idle_busy", busy, 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
